// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: shared definitions for the character-LCD refresh sequencer.
//   seq_state_t  - sequencer state encoding
//   INIT_CMDS    - HD44780 init command list (4-bit mode, entry mode, display on, clear)
//   SET_ADDR_*   - DDRAM set-address commands for line 1 / line 2
//   LINE2_BASE   - first DDRAM address of line 2
package lcd_seq_pkg;

  typedef enum logic [3:0] {
    PWRUP,
    INIT,
    CLR_WAIT,
    IDLE,
    ADDR1,
    FETCH1,
    SEND1,
    ADDR2,
    FETCH2,
    SEND2
  } seq_state_t;

  localparam int unsigned INIT_LEN = 4;
  localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{8'h28, 8'h06, 8'h0C, 8'h01};
  localparam logic [1:0] INIT_LAST = 2'(INIT_LEN - 1);

  localparam logic [7:0] SET_ADDR_L1 = 8'h80;
  localparam logic [7:0] SET_ADDR_L2 = 8'hC0;
  localparam logic [7:0] LINE2_BASE  = 8'h40;

endpackage

// File: rtl/lcd_wait_timer.sv
// lcd_wait_timer: loadable down-counter used for the power-up and clear waits.
//   clk, rst_n - clock, asynchronous active-low reset (count returns to RST_VAL)
//   load       - load load_val into the counter (has priority over counting)
//   load_val   - value to load
//   en         - decrement by one per cycle while non-zero
//   done       - counter is at zero
module lcd_wait_timer #(
  parameter int unsigned RST_VAL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        en,
  output logic        done
);

  logic [31:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'(RST_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 32'd1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_refresh_sequencer.sv
// lcd_refresh_sequencer: power-up wait, HD44780 init, then full-screen
// refreshes (line 1 at DDRAM 0x00.., line 2 at 0x40..) on request.
//   CLK, RST_N   - clock, asynchronous active-low reset
//   REFRESH_REQ  - one-cycle refresh request (collapsed into a pending flag when busy)
//   LCD_INDEX    - DDRAM position presented to the char lookup
//   LCD_CHAR     - character for LCD_INDEX, latched once per position
//   CMD_VALID/CMD_READY/CMD_RS/CMD_DATA - byte handshake towards the LCD driver
//   BUSY         - high in every state except IDLE
//   ERR          - sticky ready-timeout flag
// Optional feature: define LCD_SEQ_TIMEOUT_EN to enable the ready timeout;
// without it the sequencer waits on CMD_READY indefinitely and ERR is 0.
module lcd_refresh_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES = 750000,
  parameter int unsigned CLR_CYCLES   = 82000,
  parameter int unsigned LINE1_LEN    = 14,
  parameter int unsigned LINE2_LEN    = 8,
  parameter int unsigned TMO_CYCLES   = 1000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       REFRESH_REQ,
  output logic [7:0] LCD_INDEX,
  input  logic [7:0] LCD_CHAR,
  output logic       CMD_VALID,
  output logic       CMD_RS,
  output logic [7:0] CMD_DATA,
  input  logic       CMD_READY,
  output logic       BUSY,
  output logic       ERR
);

  localparam logic [7:0] L1_LAST = 8'(LINE1_LEN - 1);
  localparam logic [7:0] L2_LAST = LINE2_BASE + 8'(LINE2_LEN - 1);

  seq_state_t  state, state_nxt;
  logic [1:0]  init_idx;
  logic [7:0]  data_q;
  logic        pending;
  logic        gap;
  logic        xfer;
  logic        tmo_hit;
  logic        tmr_load;
  logic        tmr_en;
  logic        tmr_done;
  logic [31:0] tmr_load_val;

  assign xfer = CMD_VALID & CMD_READY;

  // ---------------------------------------------------------------- timeout
`ifdef LCD_SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        err_q;

  assign tmo_hit = CMD_VALID && !CMD_READY && (tmo_cnt == 32'(TMO_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (CMD_VALID && !CMD_READY && !tmo_hit) tmo_cnt <= tmo_cnt + 32'd1;
      else                                     tmo_cnt <= '0;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^32'(TMO_CYCLES);
  assign tmo_hit    = 1'b0;
  assign ERR        = 1'b0;
`endif

  // ------------------------------------------------------------ wait timer
  // Reloaded with CLR_CYCLES when the clear command is accepted, and with
  // PWRUP_CYCLES when a timeout forces a full re-init.
  assign tmr_load     = (state == INIT && xfer && init_idx == INIT_LAST) || tmo_hit;
  assign tmr_load_val = tmo_hit ? 32'(PWRUP_CYCLES) : 32'(CLR_CYCLES);
  assign tmr_en       = (state == PWRUP) || (state == CLR_WAIT);

  lcd_wait_timer #(
    .RST_VAL (PWRUP_CYCLES)
  ) u_wait_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  // ---------------------------------------------------------- state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= PWRUP;
    else        state <= state_nxt;
  end

  // -------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      PWRUP:    if (tmr_done) state_nxt = INIT;
      INIT:     if (xfer && init_idx == INIT_LAST) state_nxt = CLR_WAIT;
      CLR_WAIT: if (tmr_done) state_nxt = IDLE;
      IDLE:     if (REFRESH_REQ || pending) state_nxt = ADDR1;
      ADDR1:    if (xfer) state_nxt = FETCH1;
      FETCH1:   state_nxt = SEND1;
      SEND1:    if (xfer) state_nxt = (LCD_INDEX == L1_LAST) ? ADDR2 : FETCH1;
      ADDR2:    if (xfer) state_nxt = FETCH2;
      FETCH2:   state_nxt = SEND2;
      SEND2:    if (xfer) state_nxt = (LCD_INDEX == L2_LAST) ? IDLE : FETCH2;
      default:  state_nxt = PWRUP;
    endcase
    if (tmo_hit) state_nxt = PWRUP;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      init_idx  <= '0;
      LCD_INDEX <= '0;
      data_q    <= '0;
      pending   <= 1'b0;
      gap       <= 1'b0;
    end else begin
      // Forces CMD_VALID low for the cycle after every accepted byte.
      gap <= xfer;

      if (tmo_hit) begin
        init_idx <= '0;
        pending  <= 1'b1;
      end else begin
        if (state == INIT && xfer)
          init_idx <= (init_idx == INIT_LAST) ? '0 : init_idx + 2'd1;

        if (state == CLR_WAIT && tmr_done) pending <= 1'b1;
        else if (state == IDLE)            pending <= 1'b0;
        else if (REFRESH_REQ)              pending <= 1'b1;
      end

      case (state)
        ADDR1:   if (xfer) LCD_INDEX <= '0;
        ADDR2:   if (xfer) LCD_INDEX <= LINE2_BASE;
        SEND1:   if (xfer && LCD_INDEX != L1_LAST) LCD_INDEX <= LCD_INDEX + 8'd1;
        SEND2:   if (xfer && LCD_INDEX != L2_LAST) LCD_INDEX <= LCD_INDEX + 8'd1;
        FETCH1,
        FETCH2:  data_q <= LCD_CHAR;
        default: ;
      endcase
    end
  end

  // ----------------------------------------------------------------- outputs
  always_comb begin
    CMD_VALID = 1'b0;
    CMD_RS    = 1'b0;
    CMD_DATA  = '0;
    BUSY      = (state != IDLE);
    case (state)
      INIT: begin
        CMD_VALID = !gap;
        CMD_DATA  = INIT_CMDS[init_idx];
      end
      ADDR1: begin
        CMD_VALID = !gap;
        CMD_DATA  = SET_ADDR_L1;
      end
      ADDR2: begin
        CMD_VALID = !gap;
        CMD_DATA  = SET_ADDR_L2;
      end
      SEND1,
      SEND2: begin
        CMD_VALID = !gap;
        CMD_RS    = 1'b1;
        CMD_DATA  = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// tb_lcd_refresh_sequencer: self-checking bench for lcd_refresh_sequencer.
// Shortened wait parameters; char lookup returns 0x30 + (index & 0xF) + bias.
// Define LCD_SEQ_TIMEOUT_EN to also exercise the ready timeout.
module tb_lcd_refresh_sequencer;

  localparam int PWRUP = 40;
  localparam int CLR   = 20;
  localparam int L1    = 14;
  localparam int L2    = 8;
  localparam int TMO   = 60;
  localparam int REF_LEN = L1 + L2 + 2;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       REFRESH_REQ = 1'b0;
  logic [7:0] LCD_INDEX;
  logic [7:0] LCD_CHAR;
  logic       CMD_VALID;
  logic       CMD_RS;
  logic [7:0] CMD_DATA;
  logic       CMD_READY = 1'b1;
  logic       BUSY;
  logic       ERR;

  logic [7:0] bias = 8'h00;
  bit         rand_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Observed transfers (written by the monitor only) and expected stream.
  logic [8:0] got_q[$];
  int         got_cyc[$];
  logic [8:0] exp_q[$];
  int         cyc = 0;
  int         viol = 0;
  logic       prev_valid = 1'b0;
  logic       prev_xfer = 1'b0;
  logic [8:0] prev_word = '0;

  assign LCD_CHAR = 8'h30 + {4'h0, LCD_INDEX[3:0]} + bias;

  lcd_refresh_sequencer #(
    .PWRUP_CYCLES (PWRUP),
    .CLR_CYCLES   (CLR),
    .LINE1_LEN    (L1),
    .LINE2_LEN    (L2),
    .TMO_CYCLES   (TMO)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .REFRESH_REQ (REFRESH_REQ),
    .LCD_INDEX   (LCD_INDEX),
    .LCD_CHAR    (LCD_CHAR),
    .CMD_VALID   (CMD_VALID),
    .CMD_RS      (CMD_RS),
    .CMD_DATA    (CMD_DATA),
    .CMD_READY   (CMD_READY),
    .BUSY        (BUSY),
    .ERR         (ERR)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Handshake monitor: inputs only change just after posedge, so what is
  // seen at negedge is what the DUT sees at the next posedge.
  always @(negedge CLK) begin
    if (CMD_VALID && CMD_READY) begin
      got_q.push_back({CMD_RS, CMD_DATA});
      got_cyc.push_back(cyc);
    end
    if (prev_xfer && CMD_VALID)
      viol <= viol + 1;
    else if (prev_valid && CMD_VALID && ({CMD_RS, CMD_DATA} != prev_word))
      viol <= viol + 1;
    prev_valid <= CMD_VALID;
    prev_xfer  <= CMD_VALID && CMD_READY;
    prev_word  <= {CMD_RS, CMD_DATA};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (rand_ready) CMD_READY = ($urandom_range(0, 3) != 0);
  endtask

  function automatic logic [7:0] ref_char(input logic [7:0] idx);
    return 8'h30 + (idx & 8'h0F);
  endfunction

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h28});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_refresh();
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < L1; i++) exp_q.push_back({1'b1, ref_char(8'(i))});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < L2; i++) exp_q.push_back({1'b1, ref_char(8'(8'h40 + i))});
  endtask

  task automatic check_seg(input string tag, input int base);
    logic [8:0] w;
    for (int i = 0; i < exp_q.size(); i++) begin
      w = (base + i < got_q.size()) ? got_q[base + i] : 9'h1FF;
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(w), 32'(exp_q[i]));
    end
  endtask

  task automatic wait_xfers(input string tag, input int target, input int limit);
    int k = 0;
    while (got_q.size() < target && k < limit) begin
      step();
      k++;
    end
    check_eq(tag, 32'(got_q.size() >= target), 32'd1);
  endtask

  // Power-up wait, init list, clear gap and the automatic first refresh.
  task automatic powerup_seq(input string tag, input bit release_rst);
    int n = 0;
    int base;
    base = got_q.size();
    rand_ready = 1'b0;
    CMD_READY  = 1'b1;
    if (release_rst) RST_N = 1'b1;
    while (!CMD_VALID && n < PWRUP + 50) begin
      step();
      n++;
    end
    check_eq({tag, "_pwrup_wait_in_range"}, 32'(n >= PWRUP && n <= PWRUP + 2), 32'd1);
    wait_xfers({tag, "_xfers_done"}, base + 4 + REF_LEN, 2000);
    check_eq({tag, "_busy_after_last"}, 32'(BUSY), 32'd0);
    check_eq({tag, "_index_hold"}, 32'(LCD_INDEX), 32'h47);
    exp_q.delete();
    push_init();
    push_refresh();
    check_seg(tag, base);
    if (got_cyc.size() >= base + 7) begin
      check_eq({tag, "_clr_gap_in_range"},
               32'(got_cyc[base + 4] - got_cyc[base + 3] >= CLR &&
                   got_cyc[base + 4] - got_cyc[base + 3] <= CLR + 4), 32'd1);
      check_eq({tag, "_byte_spacing"}, 32'(got_cyc[base + 6] - got_cyc[base + 5]), 32'd2);
    end
  endtask

  initial begin
    int base;
    int k;
    int pulse_i;
    int tgt[3];
    logic [7:0] data0;

    // ---- reset values
    #2 RST_N = 1'b0;
    step();
    step();
    check_eq("rst_cmd_valid", 32'(CMD_VALID), 32'd0);
    check_eq("rst_cmd_rs", 32'(CMD_RS), 32'd0);
    check_eq("rst_cmd_data", 32'(CMD_DATA), 32'd0);
    check_eq("rst_lcd_index", 32'(LCD_INDEX), 32'd0);
    check_eq("rst_busy", 32'(BUSY), 32'd1);
    check_eq("rst_err", 32'(ERR), 32'd0);

    // ---- power-up, init and first refresh
    powerup_seq("boot", 1'b1);

    // ---- stall in SEND1 with the char source changing, then random ready
    //      and three extra requests collapsing into one refresh
    base = got_q.size();
    REFRESH_REQ = 1'b1;
    step();
    REFRESH_REQ = 1'b0;
    k = 0;
    while (!(CMD_VALID && CMD_RS && LCD_INDEX == 8'h03) && k < 200) begin
      step();
      k++;
    end
    check_eq("stall_reached_send1", 32'(CMD_VALID && CMD_RS && LCD_INDEX == 8'h03), 32'd1);
    CMD_READY = 1'b0;
    data0 = CMD_DATA;
    check_eq("stall_data_value", 32'(data0), 32'h33);
    k = got_q.size();
    bias = 8'h10;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stall_valid", 32'(CMD_VALID), 32'd1);
      check_eq("stall_rs", 32'(CMD_RS), 32'd1);
      check_eq("stall_data", 32'(CMD_DATA), 32'(data0));
    end
    bias = 8'h00;
    CMD_READY = 1'b1;
    step();
    check_eq("stall_one_transfer", 32'(got_q.size() - k), 32'd1);
    check_eq("stall_valid_gap", 32'(CMD_VALID), 32'd0);

    tgt[0] = $urandom_range(5, 9);
    tgt[1] = $urandom_range(10, 15);
    tgt[2] = $urandom_range(16, 22);
    pulse_i = 0;
    rand_ready = 1'b1;
    k = 0;
    while (got_q.size() < base + 2 * REF_LEN && k < 1000) begin
      REFRESH_REQ = 1'b0;
      if (pulse_i < 3 && (got_q.size() - base) >= tgt[pulse_i]) begin
        REFRESH_REQ = 1'b1;
        pulse_i++;
      end
      step();
      k++;
    end
    REFRESH_REQ = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_eq("multi_req_one_extra", 32'(got_q.size() - base), 32'(2 * REF_LEN));
    check_eq("multi_req_idle", 32'(BUSY), 32'd0);
    exp_q.delete();
    push_refresh();
    push_refresh();
    check_seg("multi_req", base);

    // ---- request on the final transfer cycle
    rand_ready = 1'b0;
    CMD_READY  = 1'b1;
    base = got_q.size();
    REFRESH_REQ = 1'b1;
    step();
    REFRESH_REQ = 1'b0;
    k = 0;
    while (!(CMD_VALID && CMD_RS && LCD_INDEX == 8'h47) && k < 200) begin
      step();
      k++;
    end
    REFRESH_REQ = 1'b1;
    step();
    REFRESH_REQ = 1'b0;
    check_eq("lastreq_idle_busy", 32'(BUSY), 32'd0);
    check_eq("lastreq_idle_valid", 32'(CMD_VALID), 32'd0);
    step();
    check_eq("lastreq_restart_busy", 32'(BUSY), 32'd1);
    check_eq("lastreq_restart_valid", 32'(CMD_VALID), 32'd1);
    check_eq("lastreq_restart_cmd", 32'({CMD_RS, CMD_DATA}), 32'h080);
    wait_xfers("lastreq_xfers_done", base + 2 * REF_LEN, 500);
    exp_q.delete();
    push_refresh();
    push_refresh();
    check_seg("lastreq", base);

    // ---- reset in the middle of line 2
    REFRESH_REQ = 1'b1;
    step();
    REFRESH_REQ = 1'b0;
    k = 0;
    while (!(CMD_VALID && LCD_INDEX == 8'h43) && k < 200) begin
      step();
      k++;
    end
    RST_N = 1'b0;
    #1;
    check_eq("midrst_valid_async", 32'(CMD_VALID), 32'd0);
    check_eq("midrst_busy", 32'(BUSY), 32'd1);
    check_eq("midrst_index", 32'(LCD_INDEX), 32'd0);
    step();
    step();
    powerup_seq("reboot", 1'b1);

`ifdef LCD_SEQ_TIMEOUT_EN
    // ---- ready stuck low: timeout, sticky ERR, full re-init
    CMD_READY = 1'b0;
    REFRESH_REQ = 1'b1;
    step();
    REFRESH_REQ = 1'b0;
    k = 0;
    while (!ERR && k < TMO + 20) begin
      step();
      k++;
    end
    check_eq("tmo_latency_in_range", 32'(k >= TMO - 1 && k <= TMO + 1), 32'd1);
    check_eq("tmo_err", 32'(ERR), 32'd1);
    check_eq("tmo_valid_dropped", 32'(CMD_VALID), 32'd0);
    check_eq("tmo_busy", 32'(BUSY), 32'd1);
    powerup_seq("tmo_reinit", 1'b0);
    check_eq("tmo_err_sticky", 32'(ERR), 32'd1);
`else
    check_eq("err_tied_low", 32'(ERR), 32'd0);
`endif

    check_eq("handshake_protocol_violations", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
